// File: rtl/score_pkg.sv
// Shared types and defaults for the score keeper: BCD digit/score types,
// FSM state encoding and the saturated score value.
package score_pkg;

    localparam int SK_DISP_W      = 8;
    localparam int SK_ACC_W       = 10;
    localparam int SK_DIGITS      = 6;
    localparam int SK_CONV_DIGITS = 4;   // enough decimal digits for 2^ACC_W-1

    typedef logic [3:0] bcd_t;
    typedef bcd_t [SK_DIGITS-1:0] score_t;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        CONVERT,
        ADD,
        CHECK
    } sk_state_e;

    localparam score_t SCORE_MAX = {SK_DIGITS{4'h9}};

endpackage

// File: rtl/score_keeper_bcd_digit_adder.sv
// Combinational single-digit BCD adder with decimal carry in and out.
module bcd_digit_adder (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);

    logic [4:0] raw;

    always_comb begin
        raw  = {1'b0, a} + {1'b0, b} + {4'b0000, cin};
        cout = (raw > 5'd9);
        sum  = cout ? 4'(raw - 5'd10) : raw[3:0];
    end

endmodule

// File: rtl/score_keeper.sv
// Accumulates per-frame scroll displacement into a saturating BCD score
// using a digit-serial binary-to-BCD conversion and BCD add; tracks the high score.
module score_keeper
    import score_pkg::*;
#(
    parameter int DISP_W = SK_DISP_W,
    parameter int ACC_W  = SK_ACC_W,
    parameter int DIGITS = SK_DIGITS
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic                  frame_clk,
    input  logic                  refresh_en,
    input  logic [DISP_W-1:0]     displacement,
    input  logic                  game_start,
    input  logic                  game_over,
    output logic [4*DIGITS-1:0]   score_bcd,
    output logic [4*DIGITS-1:0]   high_bcd,
    output logic                  new_high,
    output logic                  busy
);

    localparam int CNT_W = $clog2(ACC_W > DIGITS ? ACC_W : DIGITS) + 1;
    localparam logic [4*DIGITS-1:0] MAX_VAL = {DIGITS{4'h9}};

    logic                          fs1, fs2, fs3;
    logic                          tick, capture;
    logic                          go_prev, go_rise, commit_wait, commit;
    logic [ACC_W-1:0]              pending, pend_base, pend_sat, work;
    logic [ACC_W:0]                pend_sum;
    bcd_t [SK_CONV_DIGITS-1:0]     conv;
    logic [4*SK_CONV_DIGITS-1:0]   conv_adj;
    bcd_t [DIGITS-1:0]             sum_sr;
    logic                          carry;
    logic [3:0]                    dsum;
    logic                          dcout;
    logic                          last_add;
    logic [CNT_W-1:0]              cnt;
    sk_state_e                     state, state_nx;

    // frame_clk is asynchronous: two-flop synchroniser plus rising-edge detect.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            fs1 <= 1'b1;
            fs2 <= 1'b1;
            fs3 <= 1'b1;
        end else begin
            fs1 <= frame_clk;
            fs2 <= fs1;
            fs3 <= fs2;
        end
    end

    assign tick    = fs2 & ~fs3;
    assign capture = tick & refresh_en & ~game_over & ~game_start;
    assign go_rise = game_over & ~go_prev;
    assign commit  = (state == IDLE) & (go_rise | commit_wait) & ~game_start;

    // In LOAD the old pending moves to the work register, so a capture starts from zero.
    always_comb begin
        pend_base = (state == LOAD) ? '0 : pending;
        pend_sum  = {1'b0, pend_base} + {{(ACC_W+1-DISP_W){1'b0}}, displacement};
        pend_sat  = pend_sum[ACC_W] ? '1 : pend_sum[ACC_W-1:0];
    end

    always_comb begin
        for (int i = 0; i < SK_CONV_DIGITS; i++) begin
            conv_adj[4*i +: 4] = (conv[i] >= 4'd5) ? conv[i] + 4'd3 : conv[i];
        end
    end

    bcd_digit_adder u_adder (
        .a    (sum_sr[0]),
        .b    (conv[0]),
        .cin  (carry),
        .sum  (dsum),
        .cout (dcout)
    );

    // State register
    always_ff @(posedge Clk) begin
        if (!Reset) state <= IDLE;
        else        state <= state_nx;
    end

    // Next-state logic; game_start aborts from any state.
    always_comb begin
        state_nx = state;
        if (game_start) begin
            state_nx = IDLE;
        end else begin
            case (state)
                IDLE:    if (pending != '0 && !game_over) state_nx = LOAD;
                LOAD:    state_nx = CONVERT;
                CONVERT: if (cnt == CNT_W'(ACC_W-1)) state_nx = ADD;
                ADD:     if (cnt == CNT_W'(DIGITS-1)) state_nx = CHECK;
                CHECK:   state_nx = IDLE;
                default: state_nx = IDLE;
            endcase
        end
    end

    // Output decode
    always_comb begin
        busy     = (state != IDLE);
        last_add = (state == ADD) && (cnt == CNT_W'(DIGITS-1));
    end

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            pending     <= '0;
            work        <= '0;
            conv        <= '0;
            sum_sr      <= '0;
            carry       <= 1'b0;
            cnt         <= '0;
            score_bcd   <= '0;
            high_bcd    <= '0;
            new_high    <= 1'b0;
            go_prev     <= 1'b0;
            commit_wait <= 1'b0;
        end else begin
            go_prev <= game_over;
            if (game_start) begin
                pending     <= '0;
                score_bcd   <= '0;
                new_high    <= 1'b0;
                cnt         <= '0;
                commit_wait <= 1'b0;
            end else begin
                if (capture)            pending <= pend_sat;
                else if (state == LOAD) pending <= '0;

                case (state)
                    LOAD: begin
                        work   <= pending;
                        conv   <= '0;
                        sum_sr <= score_bcd;
                        carry  <= 1'b0;
                        cnt    <= '0;
                    end
                    CONVERT: begin
                        conv <= (conv_adj << 1) | {{(4*SK_CONV_DIGITS-1){1'b0}}, work[ACC_W-1]};
                        work <= work << 1;
                        cnt  <= (cnt == CNT_W'(ACC_W-1)) ? '0 : cnt + 1'b1;
                    end
                    ADD: begin
                        // sum_sr rotates so the digit being added is always at index 0.
                        sum_sr <= {dsum, sum_sr[DIGITS-1:1]};
                        conv   <= {4'h0, conv[SK_CONV_DIGITS-1:1]};
                        carry  <= dcout;
                        cnt    <= cnt + 1'b1;
                        if (last_add) score_bcd <= dcout ? MAX_VAL : {dsum, sum_sr[DIGITS-1:1]};
                    end
                    default: ;
                endcase

                // Valid BCD compares correctly as a plain unsigned number, MSD first.
                if (commit) begin
                    commit_wait <= 1'b0;
                    if (score_bcd > high_bcd) begin
                        high_bcd <= score_bcd;
                        new_high <= 1'b1;
                    end
                end else if (go_rise) begin
                    commit_wait <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_score_keeper.sv
// Bench for score_keeper: integer score model with a queue of captured
// displacements; every score change must equal the old score plus a run of captures.
module tb_score_keeper;

    logic        Clk = 1'b0;
    logic        Reset = 1'b0;
    logic        frame_clk = 1'b0;
    logic        refresh_en = 1'b0;
    logic [7:0]  displacement = 8'd0;
    logic        game_start = 1'b0;
    logic        game_over = 1'b0;
    logic [23:0] score_bcd, high_bcd;
    logic        new_high, busy;

    int tests = 0;
    int fails = 0;

    int model_score = 0;
    int model_high = 0;
    int model_new_high = 0;
    int last_val = 0;
    int cap_q[$];
    bit step_bad = 0;

    always #10 Clk = ~Clk;

    score_keeper dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .frame_clk    (frame_clk),
        .refresh_en   (refresh_en),
        .displacement (displacement),
        .game_start   (game_start),
        .game_over    (game_over),
        .score_bcd    (score_bcd),
        .high_bcd     (high_bcd),
        .new_high     (new_high),
        .busy         (busy)
    );

    function automatic logic [23:0] to_bcd(input int v);
        logic [23:0] r;
        int x;
        x = v;
        for (int i = 0; i < 6; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    function automatic int sat(input int v);
        return (v > 999999) ? 999999 : v;
    endfunction

    task automatic check(input string name, input logic [23:0] act, input logic [23:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick_clk(input int n);
        repeat (n) @(posedge Clk);
        #1;
    endtask

    task automatic frame_pulse(input int disp, input bit ren, input int lo);
        displacement = 8'(disp);
        refresh_en   = ren;
        frame_clk    = 1'b1;
        if (ren && !game_over && disp != 0) begin
            cap_q.push_back(disp);
            model_score = sat(model_score + disp);
        end
        tick_clk(4);
        frame_clk = 1'b0;
        tick_clk(lo);
    endtask

    task automatic wait_quiet(input string name);
        int n;
        int idle_run;
        n = 0;
        idle_run = 0;
        tick_clk(6);
        while (idle_run < 3 && n < 300) begin
            if (!busy) idle_run++;
            else idle_run = 0;
            n++;
            tick_clk(1);
        end
        if (idle_run < 3) begin
            tests++;
            fails++;
            $display("FAIL %s_timeout: busy still %b after %0d cycles, required 0", name, busy, n);
        end
        check({name, "_score"}, score_bcd, to_bcd(model_score));
        check({name, "_busy"}, {23'b0, busy}, 24'd0);
        cap_q.delete();
        last_val = model_score;
        step_bad = 0;
    endtask

    task automatic do_game_start();
        game_start = 1'b1;
        tick_clk(1);
        game_start = 1'b0;
        model_score = 0;
        last_val = 0;
        model_new_high = 0;
        cap_q.delete();
    endtask

    task automatic end_game(input string name);
        game_over = 1'b1;
        wait_quiet(name);
        if (model_score > model_high) begin
            model_high = model_score;
            model_new_high = 1;
        end
        check({name, "_high"}, high_bcd, to_bcd(model_high));
        check({name, "_new_high"}, {23'b0, new_high}, 24'(model_new_high));
    endtask

    // Every score change must be old score plus a prefix of the captured amounts.
    always @(negedge Clk) begin : cmp
        int run;
        int k;
        bit hit;
        if (Reset && !step_bad && score_bcd !== to_bcd(last_val)) begin
            run = 0;
            k = 0;
            hit = 0;
            tests++;
            while (!hit && k < cap_q.size()) begin
                run += cap_q[k];
                if (to_bcd(sat(last_val + run)) === score_bcd) hit = 1;
                else k++;
            end
            if (hit) begin
                repeat (k + 1) void'(cap_q.pop_front());
                last_val = sat(last_val + run);
            end else begin
                fails++;
                step_bad = 1;
                $display("FAIL score_step: got %h, from %h no run of captured displacements gives it",
                         score_bcd, to_bcd(last_val));
            end
        end
    end

    initial begin
        #5ms;
        fails++;
        $display("FAIL global_timeout: simulation did not finish in time");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        int n;
        bit seen_busy;

        repeat (2) @(posedge Clk);
        #1;
        check("reset_score", score_bcd, 24'h0);
        check("reset_high", high_bcd, 24'h0);
        check("reset_new_high", {23'b0, new_high}, 24'd0);
        check("reset_busy", {23'b0, busy}, 24'd0);
        Reset = 1'b1;
        tick_clk(2);

        for (int i = 0; i < 3; i++) begin
            frame_pulse($urandom_range(1, 255), 1'b0, 3);
            check("idle_busy", {23'b0, busy}, 24'd0);
        end
        wait_quiet("idle");

        // Single add with exact latency from the asynchronous edge.
        displacement = 8'd37;
        refresh_en   = 1'b1;
        frame_clk    = 1'b1;
        cap_q.push_back(37);
        model_score = 37;
        n = 0;
        seen_busy = 0;
        while (score_bcd !== 24'h000037 && n < 40) begin
            tick_clk(1);
            n++;
            if (busy) seen_busy = 1;
            if (n == 4) frame_clk = 1'b0;
        end
        check("single_latency", 24'(n), 24'd21);
        check("single_busy_seen", {23'b0, seen_busy}, 24'd1);
        wait_quiet("single");
        check("single_literal", score_bcd, 24'h000037);

        // Decimal carry across three digits.
        frame_pulse(255, 1'b1, 25);
        frame_pulse(255, 1'b1, 25);
        frame_pulse(255, 1'b1, 25);
        frame_pulse(197, 1'b1, 25);
        wait_quiet("preload");
        check("preload_literal", score_bcd, 24'h000999);
        frame_pulse(1, 1'b1, 25);
        wait_quiet("carry");
        check("carry_literal", score_bcd, 24'h001000);

        // Second tick arrives while the first is converting.
        do_game_start();
        check("start_clear", score_bcd, 24'h0);
        frame_pulse(200, 1'b1, 1);
        frame_pulse(250, 1'b1, 10);
        wait_quiet("busy_tick");
        check("busy_tick_literal", score_bcd, 24'h000450);

        // High score commit, frozen score, restart.
        end_game("over1");
        check("over1_high_literal", high_bcd, 24'h000450);
        check("over1_new_high_literal", {23'b0, new_high}, 24'd1);
        frame_pulse(99, 1'b1, 5);
        wait_quiet("frozen");
        check("frozen_literal", score_bcd, 24'h000450);
        game_over = 1'b0;
        tick_clk(2);
        do_game_start();
        tick_clk(1);
        check("restart_score", score_bcd, 24'h0);
        check("restart_new_high", {23'b0, new_high}, 24'd0);
        check("restart_high", high_bcd, 24'h000450);
        frame_pulse(100, 1'b1, 5);
        end_game("over2");
        check("over2_high_literal", high_bcd, 24'h000450);
        check("over2_new_high_literal", {23'b0, new_high}, 24'd0);
        game_over = 1'b0;
        tick_clk(2);
        do_game_start();

        // Abort a conversion in flight.
        frame_pulse(60, 1'b1, 5);
        wait_quiet("pre_abort");
        frame_pulse(80, 1'b1, 6);
        check("abort_busy", {23'b0, busy}, 24'd1);
        do_game_start();
        wait_quiet("abort");
        check("abort_literal", score_bcd, 24'h0);

        // Randomised frames.
        for (int i = 0; i < 150; i++) begin
            frame_pulse($urandom_range(0, 255), ($urandom_range(0, 3) != 0), $urandom_range(1, 30));
            if (i % 25 == 24) wait_quiet("random");
        end
        wait_quiet("random_end");

        // Saturation at all nines.
        do_game_start();
        for (int i = 0; i < 3999; i++) frame_pulse(250, 1'b1, 1);
        frame_pulse(240, 1'b1, 5);
        wait_quiet("near_max");
        check("near_max_literal", score_bcd, 24'h999990);
        frame_pulse(25, 1'b1, 5);
        wait_quiet("saturate");
        check("saturate_literal", score_bcd, 24'h999999);
        frame_pulse(255, 1'b1, 5);
        wait_quiet("saturate_hold");
        check("saturate_hold_literal", score_bcd, 24'h999999);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/score_keeper.md
Name: score_keeper

Overview:
- Accumulates the per-frame scroll `displacement` from the jump logic into a 6-digit BCD game score, and tracks a session high score.
- Sits downstream of the jump logic, beside the color mapper; its BCD outputs feed the HEX display drivers at top level.
- Decimal arithmetic is digit-serial (double-dabble, then BCD add), so it costs little area and finishes well inside one video frame.

Parameters:
- DISP_W, 8, width of the displacement input.
- ACC_W, 10, width of the pending accumulator; saturates at 2^ACC_W-1.
- DIGITS, 6, number of BCD digits in the score and high score; saturate at all-9s.

Ports:
- Clk  in  1  system clock (50 MHz).
- Reset  in  1  synchronous, active-low reset.
- frame_clk  in  1  VGA vertical sync (VGA_VS); asynchronous to Clk.
- refresh_en  in  1  high while the screen is scrolling this frame.
- displacement  in  DISP_W  rows scrolled this frame (unsigned).
- game_start  in  1  one-Clk pulse; clears the score.
- game_over  in  1  level; freezes the score and commits the high score.
- score_bcd  out  4*DIGITS  current score, digit 0 in LSBs.
- high_bcd  out  4*DIGITS  highest score this session.
- new_high  out  1  high while a committed score exceeded the previous high.
- busy  out  1  high while the FSM is not IDLE.

Behaviour:
- Reset (Reset==0 at a Clk edge):
  - score_bcd=0, high_bcd=0, new_high=0, busy=0, pending=0.
  - FSM to IDLE; frame_clk synchroniser flops cleared to 1 so no false edge.
- Frame tick:
  - frame_clk passes through a 2-flop synchroniser, then an edge detector.
  - tick = one-Clk pulse on the synchronised rising edge.
- Capture, on tick:
  - Condition: refresh_en==1 and game_over==0.
  - pending <= min(pending + displacement, 2^ACC_W-1).
  - Capture is allowed in every state. A tick during a conversion adds to the pending sum; that work is not lost.
- FSM states: IDLE, LOAD, CONVERT, ADD, CHECK.
  - IDLE -> LOAD when pending!=0 and game_over==0.
  - LOAD: 1 cycle. Copy pending to the work register; clear pending, except that a same-cycle tick capture becomes the new pending value.
  - CONVERT: exactly ACC_W cycles of double-dabble, producing a 4-digit BCD value. Per-digit "+3 if >=5" happens before each shift.
  - ADD: exactly DIGITS cycles of digit-serial BCD add of the converted value into score_bcd, LSD first, with decimal carry.
    - If a carry leaves the MSD, score_bcd saturates to all-9s.
  - CHECK: 1 cycle, then back to IDLE.
- Latency: tick to updated score_bcd = 2 (sync) + 1 (edge) + 1 (LOAD) + ACC_W + DIGITS + 1 cycles. With defaults this is 21 cycles.
- score_bcd update rules:
  - Updates only on the final ADD cycle.
  - Holds during CONVERT, ADD and CHECK, so the HEX display shows no partial digits.
- busy = (state != IDLE).
- game_start:
  - In IDLE: score_bcd <= 0, pending <= 0, new_high <= 0 next cycle.
  - Not in IDLE: abort to IDLE and clear the same registers. Abort takes priority over any ADD write in that cycle.
  - high_bcd is preserved.
- game_over, rising level (internally edge-detected):
  - Waits until the FSM returns to IDLE.
  - Then in one cycle: if score_bcd > high_bcd (unsigned BCD compare, MSD first), high_bcd <= score_bcd and new_high <= 1.
  - While game_over==1: no new captures; pending is held; the FSM stays in IDLE.
- Simultaneous events:
  - game_start outranks game_over, which outranks tick capture.
  - A tick coinciding with game_start is dropped.
- Wrap-around: none. Both accumulators saturate; the BCD digits never exceed 9.

Decomposition:
- Shared package score_pkg holds:
  - typedef bcd_t (4 bits);
  - typedef score_t (array of DIGITS bcd_t);
  - enum sk_state_e {IDLE, LOAD, CONVERT, ADD, CHECK};
  - constant SCORE_MAX (all-9s).
- One natural sub-module, bcd_digit_adder: a combinational single-digit BCD add. Inputs a, b, cin; outputs sum, cout. It is instantiated once and reused serially across ADD cycles.
- The synchroniser and edge detect stay inline.

Test Plan:
- Reset then idle: hold Reset=0 for 2 Clk, release, toggle frame_clk with refresh_en=0 -> score_bcd=0, high_bcd=0, busy=0 throughout.
- Single add: refresh_en=1, displacement=8'd37, one frame_clk rising edge -> busy rises, score_bcd=24'h000037 exactly 21 Clk after the async edge, busy=0 after CHECK.
- Decimal carry: preload score via ticks to 24'h000999, then add displacement=1 -> score_bcd=24'h001000. No intermediate value ever appears on score_bcd.
- Tick while busy: two frame_clk edges 5 Clk apart, displacement=200 then 250 -> final score_bcd=24'h000450; no tick lost.
- Saturation: drive score to 24'h999990, add 8'd25 -> score_bcd=24'h999999 and stays there on further adds.
- High score/restart: score 24'h000450, assert game_over -> high_bcd=24'h000450, new_high=1. Then game_start -> score_bcd=0, new_high=0, high_bcd unchanged. A second game ending at 24'h000100 leaves high_bcd=24'h000450 and new_high=0.
